// File: rtl/sad_min_select_pkg.sv
// sad_min_select_pkg: shared widths, FSM encoding and motion-vector address split.
package sad_min_select_pkg;
  localparam int SAD_W_D  = 13;
  localparam int ADDR_W_D = 8;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_ACCUM = 2'd2,
    S_HOLD  = 2'd3
  } state_t;
  function automatic logic [3:0] mv_y(input logic [7:0] addr);
    return addr[7:4];
  endfunction
  function automatic logic [3:0] mv_x(input logic [7:0] addr);
    return addr[3:0];
  endfunction
endpackage

// File: rtl/sad_min_select_cmp_lt.sv
// sad_cmp_lt: combinational unsigned strict less-than; equal values never win so the earliest tie holds.
module sad_cmp_lt #(
  parameter int W = 13
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_lt
);
  assign o_lt = i_a < i_b;
endmodule

// File: rtl/sad_min_select.sv
// sad_min_select: tracks the minimum-SAD candidate over one search window and
// hands {best_sad, best_addr} downstream over a valid/ready handshake.
module sad_min_select
  import sad_min_select_pkg::*;
#(
  parameter int SAD_W    = SAD_W_D,
  parameter int ADDR_W   = ADDR_W_D,
  parameter int PIPE_LAT = 6,
  parameter int NUM_CAND = 64,
  parameter int CNT_W    = $clog2(NUM_CAND + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [SAD_W+ADDR_W-1:0] res_in,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    out_valid,
  output logic [SAD_W-1:0]        best_sad,
  output logic [ADDR_W-1:0]       best_addr,
  output logic [CNT_W-1:0]        cand_cnt
);
  localparam int LAT_W = $clog2(PIPE_LAT + 1);

  state_t             r_state, w_next;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [SAD_W-1:0]   r_best_sad;
  logic [ADDR_W-1:0]  r_best_addr;
  logic [CNT_W-1:0]   r_cand_cnt;
  logic [SAD_W-1:0]   w_sad;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_lt;
  logic               w_restart;
  logic               w_last;

  assign w_sad     = res_in[SAD_W+ADDR_W-1:ADDR_W];
  assign w_addr    = res_in[ADDR_W-1:0];
  // start is honoured everywhere except HOLD, so a finished result is never lost
  assign w_restart = start && (r_state != S_HOLD);
  assign w_last    = r_cand_cnt == CNT_W'(NUM_CAND - 1);

  sad_cmp_lt #(.W(SAD_W)) u_cmp (
    .i_a  (w_sad),
    .i_b  (r_best_sad),
    .o_lt (w_lt)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_FLUSH : S_IDLE;
      S_FLUSH: w_next = start ? S_FLUSH : (r_lat_cnt == '0 ? S_ACCUM : S_FLUSH);
      S_ACCUM: w_next = start ? S_FLUSH : (w_last ? S_HOLD : S_ACCUM);
      S_HOLD:  w_next = out_ready ? S_IDLE : S_HOLD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lat_cnt   <= '0;
      r_best_sad  <= '1;
      r_best_addr <= '0;
      r_cand_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_restart) begin
        r_lat_cnt   <= LAT_W'(PIPE_LAT - 1);
        r_best_sad  <= '1;
        r_best_addr <= '0;
        r_cand_cnt  <= '0;
      end else if (r_state == S_FLUSH) begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end else if (r_state == S_ACCUM) begin
        r_cand_cnt <= r_cand_cnt + 1'b1;
        if (w_lt) begin
          r_best_sad  <= w_sad;
          r_best_addr <= w_addr;
        end
      end
    end
  end

  assign busy      = (r_state == S_FLUSH) || (r_state == S_ACCUM);
  assign out_valid = r_state == S_HOLD;
  assign best_sad  = r_best_sad;
  assign best_addr = r_best_addr;
  assign cand_cnt  = r_cand_cnt;
endmodule

// File: tb/tb_sad_min_select.sv
// tb_sad_min_select: directed windows with a result scoreboard for sad_min_select.
module tb_sad_min_select;
  import sad_min_select_pkg::*;
  localparam int SW = 13;
  localparam int AW = 8;
  localparam int N  = 64;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [SW+AW-1:0] res_in = '0;
  logic          busy, out_valid;
  logic [SW-1:0] best_sad;
  logic [AW-1:0] best_addr;
  logic [CW-1:0] cand_cnt;

  sad_min_select dut (
    .clk(clk), .rst_n(rst_n), .start(start), .res_in(res_in),
    .out_ready(out_ready), .busy(busy), .out_valid(out_valid),
    .best_sad(best_sad), .best_addr(best_addr), .cand_cnt(cand_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [SW-1:0] s; logic [AW-1:0] a;} res_t;
  res_t          sb[$];
  logic [SW-1:0] sad_v[N];
  logic [AW-1:0] addr_v[N];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected winner: strict less-than from the all-ones sentinel, address 0
  function automatic res_t model();
    res_t r;
    r.s = '1;
    r.a = '0;
    for (int i = 0; i < N; i++)
      if (sad_v[i] < r.s) begin
        r.s = sad_v[i];
        r.a = addr_v[i];
      end
    return r;
  endfunction

  task automatic begin_window();
    @(negedge clk);
    start  = 1'b1;
    res_in = {13'd0, 8'hEE};
    @(negedge clk);
    start = 1'b0;
    chk("busy_flush", 32'(busy), 32'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      res_in = {sad_v[i], addr_v[i]};
      if (i == N - 1) begin
        chk("no_valid_early", 32'(out_valid), 32'd0);
        chk("cnt_before_last", 32'(cand_cnt), 32'd63);
        sb.push_back(model());
      end
      @(negedge clk);
    end
    res_in = {13'd0, 8'hEE};
  endtask

  task automatic get_result(input string tag);
    res_t e;
    int w = 0;
    while (!out_valid && w < 8) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_latency_extra"}, 32'(w), 32'd0);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_sad"}, 32'(best_sad), 32'(e.s));
      chk({tag, "_addr"}, 32'(best_addr), 32'(e.a));
      chk({tag, "_mv"}, {24'd0, mv_y(best_addr), mv_x(best_addr)}, {24'd0, mv_y(e.a), mv_x(e.a)});
    end
    chk({tag, "_cnt"}, 32'(cand_cnt), 32'd64);
    chk({tag, "_busy_hold"}, 32'(busy), 32'd0);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("accept_valid", 32'(out_valid), 32'd0);
    chk("accept_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    // 1: reset then idle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sad", 32'(best_sad), 32'h1FFF);
    chk("rst_addr", 32'(best_addr), 32'd0);
    chk("rst_cnt", 32'(cand_cnt), 32'd0);

    // 2: descending SADs, last candidate wins (37 @ 63), exact latency
    for (int i = 0; i < N; i++) begin
      sad_v[i]  = SW'(100 - i);
      addr_v[i] = AW'(i);
    end
    begin_window();
    feed(N);
    chk("t2_valid_at_71", 32'(out_valid), 32'd1);
    chk("t2_sad_const", 32'(best_sad), 32'd37);
    chk("t2_addr_const", 32'(best_addr), 32'd63);
    get_result("t2");
    accept();
    chk("t2_idle_sad_held", 32'(best_sad), 32'd37);

    // 3: tie at 5 on idx 10 and 20, first wins
    for (int i = 0; i < N; i++) begin
      sad_v[i]  = (i == 10 || i == 20) ? SW'(5) : SW'(50);
      addr_v[i] = AW'(i);
    end
    begin_window();
    feed(N);
    chk("t3_sad_const", 32'(best_sad), 32'd5);
    chk("t3_addr_const", 32'(best_addr), 32'd10);
    get_result("t3");

    // 4: stall in HOLD, start pulse ignored, then accept with start in the same cycle
    for (int c = 0; c < 20; c++) begin
      start = (c == 10);
      @(negedge clk);
      if (c % 5 == 4) begin
        chk("t4_hold_valid", 32'(out_valid), 32'd1);
        chk("t4_hold_sad", 32'(best_sad), 32'd5);
        chk("t4_hold_addr", 32'(best_addr), 32'd10);
      end
    end
    start = 1'b0;
    chk("t4_hold_cnt", 32'(cand_cnt), 32'd64);
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    chk("t4_accept_valid", 32'(out_valid), 32'd0);
    chk("t4_start_dropped", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_still_idle", 32'(busy), 32'd0);
    chk("t4_idle_addr_held", 32'(best_addr), 32'd10);

    // 5: restart at ACCUM candidate 30; only the second window is reported
    for (int i = 0; i < N; i++) begin
      sad_v[i]  = (i == 5) ? SW'(1) : SW'(200);
      addr_v[i] = AW'(8'h80 + i);
    end
    begin_window();
    feed(30);
    chk("t5_cnt_mid", 32'(cand_cnt), 32'd30);
    for (int i = 0; i < N; i++) begin
      sad_v[i]  = (i == 3) ? SW'(7) : SW'(300 + i);
      addr_v[i] = AW'(i);
    end
    begin_window();
    chk("t5_restart_cnt", 32'(cand_cnt), 32'd0);
    chk("t5_restart_sad", 32'(best_sad), 32'h1FFF);
    feed(N);
    chk("t5_sad_const", 32'(best_sad), 32'd7);
    chk("t5_addr_const", 32'(best_addr), 32'd3);
    get_result("t5");
    accept();

    // all-ones SADs never beat the sentinel: best_addr stays 0
    for (int i = 0; i < N; i++) begin
      sad_v[i]  = '1;
      addr_v[i] = AW'(i + 1);
    end
    begin_window();
    feed(N);
    chk("ones_sad", 32'(best_sad), 32'h1FFF);
    chk("ones_addr_stays_0", 32'(best_addr), 32'd0);
    get_result("ones");
    accept();

    // random unsigned SADs incl. MSB-set values
    for (int i = 0; i < N; i++) begin
      sad_v[i]  = SW'($urandom_range(0, 8191));
      addr_v[i] = AW'($urandom_range(0, 255));
    end
    sad_v[17] = 13'h0003;
    sad_v[2]  = 13'h1002;
    begin_window();
    feed(N);
    get_result("rand");
    accept();

    // 6: async reset at ACCUM candidate 40
    for (int i = 0; i < N; i++) begin
      sad_v[i]  = SW'(i + 2);
      addr_v[i] = AW'(i + 9);
    end
    begin_window();
    feed(40);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_sad", 32'(best_sad), 32'h1FFF);
    chk("t6_rst_addr", 32'(best_addr), 32'd0);
    chk("t6_rst_cnt", 32'(cand_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (out_valid || busy) chk("t6_idle_after_rst", {30'd0, out_valid, busy}, 32'd0);
    end
    chk("t6_idle_valid", 32'(out_valid), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
